mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 142 ++++++++++++++
 tb/tb_mdu_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up and a single-cycle done pulse.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             alu_stall,
  output logic             alu_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_raw, mag_a, mag_b, quo;
  logic [WIDTH:0]     rem;
  logic [2*WIDTH-1:0] acc;

  // op[0]=0 selects the signed variants (MULT, DIV); op[1]=1 selects divide.
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  assign in_neg_a = ~op[0] & a[WIDTH-1];
  assign in_neg_b = ~op[0] & b[WIDTH-1];
  assign in_mag_a = in_neg_a ? -a : a;
  assign in_mag_b = in_neg_b ? -b : b;

  // acc holds {partial product, remaining multiplier bits}; bit 0 is the current multiplier bit.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};

  logic [WIDTH+1:0] div_sh;
  logic             div_ge;
  logic [WIDTH:0]   rem_nxt;
  assign div_sh  = {rem, quo[WIDTH-1]};
  assign div_ge  = div_sh >= {2'b00, mag_b};
  assign rem_nxt = div_ge ? (div_sh[WIDTH:0] - {1'b0, mag_b}) : div_sh[WIDTH:0];

  logic               neg_res, div_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;
  assign neg_res  = ~op_r[0] & (sign_a ^ sign_b);
  assign div_zero = (mag_b == '0);
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = (~op_r[0] & sign_a) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (op_r[1]) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    // Flush wins over everything, including the FIX-to-DONE commit.
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: datapath registers are reset too, so hi/lo read zero after reset and no X leaks into the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_raw  <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      quo    <= '0;
      rem    <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          cnt    <= '0;
          op_r   <= op;
          sign_a <= in_neg_a;
          sign_b <= in_neg_b;
          a_raw  <= a;
          mag_a  <= in_mag_a;
          mag_b  <= in_mag_b;
          quo    <= in_mag_a;
          rem    <= '0;
          acc    <= {{WIDTH{1'b0}}, in_mag_b};
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_r[1]) begin
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: if (!flush) begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign alu_stall = rst & ~flush & (((state == IDLE) & start) | (state == CALC) | (state == FIX));
  assign alu_done  = rst & ~flush & (state == DONE);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a timeline/arithmetic reference model compared
// every cycle, plus directed literal cases and randomized operations.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        alu_stall, alu_done;
  logic [31:0] hi, lo;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .alu_stall(alu_stall), .alu_done(alu_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Architectural result {hi, lo} straight from the operation's arithmetic definition.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    logic [31:0] q, r;
    case (o)
      2'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      2'd1: return {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == 2'd2) begin
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          return {r, q};
        end
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Timeline model: an accepted start at cycle t0 stalls t0..t0+33, commits hi/lo at the
  // end of t0+33 and pulses done at t0+34; flush or reset abandons the operation.
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        exp_stall, exp_done;
  int          age;

  always @(negedge clk) begin
    exp_stall = 1'b0;
    exp_done  = 1'b0;
    age       = cyc - m_t0;
    if (!rst) begin
      m_active = 1'b0;
      m_hi     = '0;
      m_lo     = '0;
    end else if (m_active) begin
      exp_stall = (age <= 33) && !flush;
      exp_done  = (age == 34) && !flush;
    end else begin
      exp_stall = start && !flush;
    end
    check("stall", 64'(alu_stall), 64'(exp_stall));
    check("done",  64'(alu_done),  64'(exp_done));
    check("hi",    64'(hi),        64'(m_hi));
    check("lo",    64'(lo),        64'(m_lo));
    if (rst) begin
      if (m_active) begin
        if (flush)            m_active = 1'b0;
        else if (age == 33)   {m_hi, m_lo} = m_pend;
        else if (age == 34)   m_active = 1'b0;
      end else if (start && !flush) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_pend   = ref_result(op, a, b);
      end
    end
  end

  // Stall-run length and done-pulse count for the latency checks.
  int run_len = 0, last_run = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (alu_done) done_cnt++;
    if (alu_stall) run_len++;
    else if (run_len > 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble operands while it runs, return start and done cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit keep_start, output int t_start, output int t_done);
    bit got = 1'b0;
    start   = 1'b1;
    op      = o;
    a       = x;
    b       = y;
    flush   = 1'b0;
    t_start = cyc;
    t_done  = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (alu_done) begin
        t_done = cyc;
        got    = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom);
    end
    if (!got) check("done_timeout", 64'(got), 64'd1);
    next_cycle();
    if (!keep_start) start = 1'b0;
  endtask

  int          ts, td, ts2, td2, dc;
  logic [31:0] sh, sl;

  initial begin
    rst = 1'b0; start = 1'b1; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) next_cycle();
    check("rst_stall", 64'(alu_stall), 64'd0);
    check("rst_done",  64'(alu_done),  64'd0);
    check("rst_hilo",  {hi, lo},       64'd0);
    rst = 1'b1; start = 1'b0;
    next_cycle();

    check("model_mult",  ref_result(2'd0, 32'd7, 32'hFFFFFFFD),          64'hFFFFFFFF_FFFFFFEB);
    check("model_divu",  ref_result(2'd3, 32'd100, 32'd7),               64'h00000002_0000000E);
    check("model_div",   ref_result(2'd2, 32'hFFFFFFF9, 32'd2),          64'hFFFFFFFF_FFFFFFFD);
    check("model_ovf",   ref_result(2'd2, 32'h80000000, 32'hFFFFFFFF),   64'h00000000_80000000);
    check("model_multu", ref_result(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF),   64'hFFFFFFFE_00000001);
    check("model_dz",    ref_result(2'd3, 32'h1234, 32'd0),              64'h00001234_FFFFFFFF);

    run_op(2'd0, 32'd7, 32'hFFFFFFFD, 1'b0, ts, td);
    check("mult_hilo",    {hi, lo},         64'hFFFFFFFF_FFFFFFEB);
    check("mult_latency", 64'(td - ts),     64'd34);
    check("mult_stall",   64'(last_run),    64'd34);

    run_op(2'd3, 32'd100, 32'd7, 1'b0, ts, td);
    check("divu_hilo", {hi, lo}, 64'h00000002_0000000E);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, ts, td);
    check("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, ts, td);
    check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, ts, td);
    check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'd3, 32'h1234, 32'd0, 1'b0, ts, td);
    check("dz_hilo",    {hi, lo},     64'h00001234_FFFFFFFF);
    check("dz_latency", 64'(td - ts), 64'd34);

    // Flush ten iterations into CALC: nothing committed, no done, next op completes.
    sh = hi; sl = lo; dc = done_cnt;
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    repeat (11) next_cycle();
    flush = 1'b1;
    #1 check("flush_stall", 64'(alu_stall), 64'd0);
    next_cycle();
    flush = 1'b0; start = 1'b0;
    repeat (40) next_cycle();
    check("flush_hilo", {hi, lo},          {sh, sl});
    check("flush_done", 64'(done_cnt - dc), 64'd0);
    run_op(2'd3, 32'd1000, 32'd3, 1'b0, ts, td);
    check("post_flush_hilo", {hi, lo}, 64'h00000001_0000014D);

    // Reset mid-CALC: immediate idle and zeroed results, stall held low with start high.
    start = 1'b1; op = 2'd0; a = 32'd12345; b = 32'd678;
    repeat (5) next_cycle();
    rst = 1'b0;
    #1;
    check("mid_rst_hilo",  {hi, lo},         64'd0);
    check("mid_rst_stall", 64'(alu_stall),   64'd0);
    check("mid_rst_done",  64'(alu_done),    64'd0);
    repeat (2) next_cycle();
    rst = 1'b1; start = 1'b0;
    next_cycle();

    // Back-to-back MULTs: second start on the first IDLE cycle after DONE.
    run_op(2'd0, 32'hFFFFFFFF, 32'd5, 1'b1, ts, td);
    run_op(2'd0, 32'd3, 32'd9, 1'b0, ts2, td2);
    check("b2b_spacing", 64'(td2 - td), 64'd35);
    check("b2b_hilo",    {hi, lo},      64'd27);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      bit          keep;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = $urandom_range(1, 15);
        3: x = $urandom_range(0, 1000);
        default: ;
      endcase
      keep = 1'($urandom_range(0, 1));
      run_op(o, x, y, keep, ts, td);
      check("rand_latency", 64'(td - ts), 64'd34);
      if (!keep) repeat ($urandom_range(0, 2)) next_cycle();
    end
    start = 1'b0;
    repeat (3) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
